// File: rtl/pu_mac_pipe.sv
// Pipelined multiply-accumulate unit: CH lane products, a registered adder tree and a
// frame accumulator with saturation, valid/ready handshakes on both sides.
module pu_mac_pipe #(
  parameter int XLEN  = 5,
  parameter int CH    = 4,
  parameter int FRAME = 2,
  parameter int ACC_W = 2*XLEN + $clog2(CH) + $clog2(FRAME)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [CH*XLEN-1:0]   in_data,
  input  logic [CH*XLEN-1:0]   in_weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_result,
  output logic                 out_sat
);

  localparam int LV = $clog2(CH);
  localparam int PW = 2*XLEN;
  localparam int TW = PW + LV;
  localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  // Approximate mode keeps only the top three data bits of each lane.
  localparam logic [XLEN-1:0] TRUNC_MASK = {{3{1'b1}}, {(XLEN-3){1'b0}}};

  logic              en_s;
  logic [XLEN-1:0]   lane_d_s [CH];
  logic [PW-1:0]     prod_s   [CH];
  logic [PW-1:0]     prod_r   [CH];
  logic              p_vld_r;
  logic              p_last_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic              last_s;
  logic [TW-1:0]     tree_sum_s;
  logic              top_vld_s;
  logic              top_last_s;
  logic [ACC_W-1:0]  acc_r;
  logic              sat_r;
  logic [SW-1:0]     sum_ext_s;
  logic              ovf_s;
  logic [ACC_W-1:0]  clamp_s;
  logic              sat_nxt_s;

  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  // Per-lane operand selection and multiply
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      lane_d_s[i] = {XLEN{1'b0}};
      prod_s[i]   = {PW{1'b0}};
    end
    for (int i = 0; i < CH; i++) begin
      if (in_mode) begin
        lane_d_s[i] = in_data[i*XLEN +: XLEN] & TRUNC_MASK;
      end else begin
        lane_d_s[i] = in_data[i*XLEN +: XLEN];
      end
      prod_s[i] = PW'(lane_d_s[i]) * PW'(in_weight[i*XLEN +: XLEN]);
    end
  end

  // Beat counter decode: tag the final beat of a frame and wrap
  always_comb begin
    last_s    = (cnt_r == CW'(FRAME-1));
    cnt_nxt_s = {CW{1'b0}};
    if (last_s) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1'b1);
    end
  end

  // Product stage: registers lane products on the accepting edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld_r  <= 1'b0;
      p_last_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      for (int i = 0; i < CH; i++) prod_r[i] <= {PW{1'b0}};
    end else if (clear) begin
      p_vld_r  <= 1'b0;
      p_last_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      for (int i = 0; i < CH; i++) prod_r[i] <= {PW{1'b0}};
    end else if (en_s) begin
      p_vld_r <= in_valid;
      if (in_valid) begin
        p_last_r <= last_s;
        cnt_r    <= cnt_nxt_s;
        for (int i = 0; i < CH; i++) prod_r[i] <= prod_s[i];
      end else begin
        p_last_r <= 1'b0;
      end
    end
  end

  for (genvar k = 1; k <= LV; k++) begin : g_lvl
    localparam int N = CH >> k;
    localparam int W = PW + k;
    logic [W-2:0] src_s [2*N];
    logic         src_vld_s;
    logic         src_last_s;
    logic [W-1:0] sum_r [N];
    logic         vld_r;
    logic         last_r;

    if (k == 1) begin : g_src_prod
      assign src_s      = prod_r;
      assign src_vld_s  = p_vld_r;
      assign src_last_s = p_last_r;
    end else begin : g_src_lvl
      assign src_s      = g_lvl[k-1].sum_r;
      assign src_vld_s  = g_lvl[k-1].vld_r;
      assign src_last_s = g_lvl[k-1].last_r;
    end

    // Tree level: pairwise sums, one bit wider than the level below
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_r  <= 1'b0;
        last_r <= 1'b0;
        for (int j = 0; j < N; j++) sum_r[j] <= {W{1'b0}};
      end else if (clear) begin
        vld_r  <= 1'b0;
        last_r <= 1'b0;
        for (int j = 0; j < N; j++) sum_r[j] <= {W{1'b0}};
      end else if (en_s) begin
        vld_r  <= src_vld_s;
        last_r <= src_last_s;
        for (int j = 0; j < N; j++) begin
          sum_r[j] <= {1'b0, src_s[2*j]} + {1'b0, src_s[2*j+1]};
        end
      end
    end
  end

  assign tree_sum_s = g_lvl[LV].sum_r[0];
  assign top_vld_s  = g_lvl[LV].vld_r;
  assign top_last_s = g_lvl[LV].last_r;

  // Accumulate with clamp to all-ones on overflow
  always_comb begin
    sum_ext_s = {SW{1'b0}};
    clamp_s   = {ACC_W{1'b0}};
    sum_ext_s = SW'(acc_r) + SW'(tree_sum_s);
    ovf_s     = |sum_ext_s[SW-1:ACC_W];
    if (ovf_s) begin
      clamp_s = {ACC_W{1'b1}};
    end else begin
      clamp_s = sum_ext_s[ACC_W-1:0];
    end
    sat_nxt_s = sat_r | ovf_s;
  end

  // Accumulator and result register; a last beat restarts the frame without a gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r      <= {ACC_W{1'b0}};
      sat_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= {ACC_W{1'b0}};
      out_sat    <= 1'b0;
    end else if (clear) begin
      acc_r      <= {ACC_W{1'b0}};
      sat_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= {ACC_W{1'b0}};
      out_sat    <= 1'b0;
    end else if (en_s) begin
      if (top_vld_s && top_last_s) begin
        acc_r      <= {ACC_W{1'b0}};
        sat_r      <= 1'b0;
        out_result <= clamp_s;
        out_sat    <= sat_nxt_s;
        out_valid  <= 1'b1;
      end else if (top_vld_s) begin
        acc_r     <= clamp_s;
        sat_r     <= sat_nxt_s;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pu_mac_pipe.sv
// Bench for pu_mac_pipe: default-width unit plus a 6-bit-result twin sharing the same stimulus,
// frame table with scoreboard, and hand sequences for latency, stall, reset and clear.
module tb_pu_mac_pipe;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_mode;
  logic [19:0] in_data;
  logic [19:0] in_weight;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [12:0] out_result;
  logic        out_sat;
  logic        in_ready6;
  logic        out_valid6;
  logic [5:0]  out_result6;
  logic        out_sat6;

  typedef struct {
    logic        m0;
    logic [19:0] d0;
    logic [19:0] w0;
    logic        m1;
    logic [19:0] d1;
    logic [19:0] w1;
    logic [12:0] er;
    logic        es;
    logic [5:0]  er6;
    logic        es6;
  } vec_t;

  typedef struct {
    logic [12:0] er;
    logic        es;
    logic [5:0]  er6;
    logic        es6;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  int   checks;
  int   errors;
  int   waits;

  pu_mac_pipe dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sat(out_sat)
  );

  pu_mac_pipe #(.ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready6), .in_mode(in_mode),
    .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_result(out_result6), .out_sat(out_sat6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] uni(input logic [4:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [19:0] pack4(input logic [4:0] l0, input logic [4:0] l1,
                                        input logic [4:0] l2, input logic [4:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic m, input logic [19:0] d, input logic [19:0] w);
    int n;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    in_weight = w;
    n = 0;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    waits += n;
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    send_beat(v.m0, v.d0, v.w0);
    send_beat(v.m1, v.d1, v.w1);
    e.er  = v.er;
    e.es  = v.es;
    e.er6 = v.er6;
    e.es6 = v.es6;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Scoreboard: compare every completed output handshake, sampled just before the edge
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected no result", out_result);
      end else begin
        e = sb.pop_front();
        chk("result", out_result, e.er);
        chk("sat", out_sat, e.es);
        chk("valid6", out_valid6, 1);
        chk("result6", out_result6, e.er6);
        chk("sat6", out_sat6, e.es6);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    waits  = 0;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_data = 20'd0; in_weight = 20'd0; out_ready = 1'b1;

    tbl[0] = '{1'b0, uni(5'd3),  uni(5'd2),  1'b0, uni(5'd3),  uni(5'd2),  13'd48,   1'b0, 6'd48, 1'b0};
    tbl[1] = '{1'b1, uni(5'd7),  uni(5'd2),  1'b1, uni(5'd7),  uni(5'd2),  13'd64,   1'b0, 6'd63, 1'b1};
    tbl[2] = '{1'b0, uni(5'd7),  uni(5'd2),  1'b1, uni(5'd7),  uni(5'd2),  13'd88,   1'b0, 6'd63, 1'b1};
    tbl[3] = '{1'b0, uni(5'd31), uni(5'd31), 1'b0, uni(5'd31), uni(5'd31), 13'd7688, 1'b0, 6'd63, 1'b1};
    tbl[4] = '{1'b0, uni(5'd1),  uni(5'd1),  1'b0, uni(5'd1),  uni(5'd1),  13'd8,    1'b0, 6'd8,  1'b0};
    tbl[5] = '{1'b1, uni(5'd31), uni(5'd31), 1'b1, uni(5'd31), uni(5'd31), 13'd6944, 1'b0, 6'd63, 1'b1};
    tbl[6] = '{1'b0, pack4(5'd1, 5'd2, 5'd3, 5'd4), pack4(5'd5, 5'd6, 5'd7, 5'd8),
               1'b0, pack4(5'd1, 5'd2, 5'd3, 5'd4), pack4(5'd5, 5'd6, 5'd7, 5'd8),
               13'd140, 1'b0, 6'd63, 1'b1};
    tbl[7] = '{1'b1, uni(5'd3),  uni(5'd9),  1'b0, uni(5'd3),  uni(5'd9),  13'd108,  1'b0, 6'd63, 1'b1};

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready6", in_ready6, 1);
    chk("rst_out_result6", out_result6, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Latency and single-cycle pulse of an isolated frame
    send_frame(tbl[0]);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 10);
    chk("latency_edges", n, 3);
    @(posedge clk);
    #1;
    chk("valid_pulse_drop", out_valid, 0);
    @(negedge clk);

    // Table of frames back to back at full throughput
    waits = 0;
    for (int i = 0; i < 8; i++) send_frame(tbl[i]);
    in_valid = 1'b0;
    chk("throughput_stalls", waits, 0);
    drain();

    // Result held under back-pressure, then the pending beats flow through
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(tbl[1]);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_out_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = 1'($urandom_range(1, 0));
      in_data   = 20'($urandom);
      in_weight = 20'($urandom);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_held_result", out_result, 64);
      chk("stall_held_result6", out_result6, 63);
    end
    @(negedge clk);
    #1;
    out_ready = 1'b1;
    send_frame(tbl[2]);
    send_frame(tbl[3]);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with one frame in flight and another half sent
    @(negedge clk);
    send_frame(tbl[0]);
    send_beat(tbl[4].m0, tbl[4].d0, tbl[4].w0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_result", out_result, 0);
    chk("async_rst_out_sat", out_sat, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_result6", out_result6, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(tbl[4]);
    in_valid = 1'b0;
    drain();

    // Clear after beat 0 discards the partial frame, even with a beat offered
    @(negedge clk);
    send_beat(1'b0, uni(5'd5), uni(5'd5));
    in_valid  = 1'b1;
    in_data   = uni(5'd31);
    in_weight = uni(5'd31);
    clear     = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("clear_out_valid", out_valid, 0);
    end
    send_frame(tbl[4]);
    in_valid = 1'b0;
    drain();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
